// File: rtl/lfsr_period_monitor.sv
// Fibonacci LFSR that tracks its own statistics and measures its period.
// It counts emitted ones and zeros and pattern hits, and pulses max_tick when the sequence returns to its start state.
module lfsr_period_monitor #(
  parameter int              WIDTH = 22,
  parameter logic [WIDTH-1:0] TAPS = 22'h200001,
  parameter logic [WIDTH-1:0] SEED = 22'h000001,
  parameter int              CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             stats_clear,
  input  logic [WIDTH-1:0] pattern,
  output logic             lfsr_out,
  output logic [WIDTH-1:0] lfsr_full_out,
  output logic             max_tick,
  output logic [CNT_W-1:0] period_len,
  output logic             period_valid,
  output logic [CNT_W-1:0] counterOne,
  output logic [CNT_W-1:0] counterZero,
  output logic [CNT_W-1:0] patternCounter
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam int               N_STAT  = 3;

  // Hold at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] start_reg;
  logic [CNT_W-1:0] step_cnt_reg;
  logic             max_tick_reg;
  logic [CNT_W-1:0] period_len_reg;
  logic             period_valid_reg;

  logic             fb;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] seed_eff;
  logic             emit_bit;
  logic             wrap;
  logic [CNT_W-1:0] step_cnt_inc;
  logic [N_STAT-1:0] stat_hit;

  always_comb begin
    fb           = ^(state_reg & TAPS);
    state_next   = {state_reg[WIDTH-2:0], fb};
    emit_bit     = state_reg[WIDTH-1];
    seed_eff     = (seed_in == '0) ? SEED : seed_in;
    wrap         = (state_next == start_reg);
    step_cnt_inc = sat_inc(step_cnt_reg);
    stat_hit     = '0;
    stat_hit[0]  = emit_bit;
    stat_hit[1]  = ~emit_bit;
    stat_hit[2]  = (state_reg == pattern);
  end

  // A zero seed would lock the register up, so it is replaced by SEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= SEED;
      start_reg        <= SEED;
      step_cnt_reg     <= '0;
      max_tick_reg     <= 1'b0;
      period_len_reg   <= '0;
      period_valid_reg <= 1'b0;
    end else if (load) begin
      state_reg        <= seed_eff;
      start_reg        <= seed_eff;
      step_cnt_reg     <= '0;
      max_tick_reg     <= 1'b0;
      period_len_reg   <= '0;
      period_valid_reg <= 1'b0;
    end else if (enable) begin
      state_reg    <= state_next;
      max_tick_reg <= wrap;
      if (wrap) begin
        // step_cnt_inc saturates, so an overlong period reports all-ones.
        period_len_reg   <= step_cnt_inc;
        period_valid_reg <= 1'b1;
        step_cnt_reg     <= '0;
      end else begin
        step_cnt_reg <= step_cnt_inc;
      end
    end else begin
      max_tick_reg <= 1'b0;
    end
  end

  // Statistics counters: 0 = ones, 1 = zeros, 2 = pattern hits.
  for (genvar gi = 0; gi < N_STAT; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset || load || stats_clear) begin
        cnt_reg <= '0;
      end else if (enable && stat_hit[gi]) begin
        cnt_reg <= sat_inc(cnt_reg);
      end
    end
  end

  assign lfsr_out       = state_reg[WIDTH-1];
  assign lfsr_full_out  = state_reg;
  assign max_tick       = max_tick_reg;
  assign period_len     = period_len_reg;
  assign period_valid   = period_valid_reg;
  assign counterOne     = g_stat[0].cnt_reg;
  assign counterZero    = g_stat[1].cnt_reg;
  assign patternCounter = g_stat[2].cnt_reg;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor: a 4-bit x^4+x^3+1 generator with wide counters (dut_a) and 3-bit counters (dut_b).
module tb_lfsr_period_monitor;

  logic       clk = 1'b0;
  logic       reset, enable, load, stats_clear;
  logic [3:0] seed_in, pattern;

  logic        out_a, tick_a, valid_a;
  logic [3:0]  state_a;
  logic [31:0] plen_a, one_a, zero_a, pcnt_a;

  logic        out_b, tick_b, valid_b;
  logic [3:0]  state_b;
  logic [2:0]  plen_b, one_b, zero_b, pcnt_b;

  always #5 clk = ~clk;

  lfsr_period_monitor #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'h1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
    .stats_clear(stats_clear), .pattern(pattern), .lfsr_out(out_a),
    .lfsr_full_out(state_a), .max_tick(tick_a), .period_len(plen_a),
    .period_valid(valid_a), .counterOne(one_a), .counterZero(zero_a),
    .patternCounter(pcnt_a));

  lfsr_period_monitor #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'h1), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
    .stats_clear(stats_clear), .pattern(pattern), .lfsr_out(out_b),
    .lfsr_full_out(state_b), .max_tick(tick_b), .period_len(plen_b),
    .period_valid(valid_b), .counterOne(one_b), .counterZero(zero_b),
    .patternCounter(pcnt_b));

  typedef struct {
    logic       rst, en, ld, clr;
    logic [3:0] seed;
    logic [3:0] exp_state;
    logic       exp_tick;
    int         exp_one, exp_zero, exp_pcnt, exp_plen;
    logic       exp_valid;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   ticks;

  function automatic vec_t mk(logic rst, logic en, logic ld, logic clr, logic [3:0] seed,
                              logic [3:0] st, logic tk, int o, int z, int p, int pl, logic v);
    vec_t r;
    r.rst = rst; r.en = en; r.ld = ld; r.clr = clr; r.seed = seed;
    r.exp_state = st; r.exp_tick = tk; r.exp_one = o; r.exp_zero = z;
    r.exp_pcnt = p; r.exp_plen = pl; r.exp_valid = v;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic ld, input logic clr,
                       input logic [3:0] seed);
    reset = rst; enable = en; load = ld; stats_clear = clr; seed_in = seed;
  endtask

  // Apply the driven inputs across one rising edge, then sample 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (tick_a) ticks++;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    ticks = 0;
  endtask

  task automatic steps(input int n);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < n; i++) cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    pattern = 4'h6;
    ticks   = 0;

    //              rst en ld clr seed  state tick one zero pcnt plen valid
    vecs[0]  = mk(1, 0, 0, 0, 4'h0, 4'h1, 0, 0, 0, 0,  0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 4'h0, 4'h3, 0, 0, 1, 0,  0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 4'h0, 4'h7, 0, 0, 2, 0,  0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 4'h0, 4'hF, 0, 0, 3, 0,  0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 4'h0, 4'hE, 0, 1, 3, 0,  0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 4'h0, 4'hD, 0, 2, 3, 0,  0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 4'h0, 4'hA, 0, 3, 3, 0,  0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 4'h0, 4'h5, 0, 4, 3, 0,  0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 4'h0, 4'hB, 0, 4, 4, 0,  0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 4'h0, 4'h6, 0, 5, 4, 0,  0, 0);
    vecs[10] = mk(0, 1, 0, 0, 4'h0, 4'hC, 0, 5, 5, 1,  0, 0);
    vecs[11] = mk(0, 1, 0, 0, 4'h0, 4'h9, 0, 6, 5, 1,  0, 0);
    vecs[12] = mk(0, 1, 0, 0, 4'h0, 4'h2, 0, 7, 5, 1,  0, 0);
    vecs[13] = mk(0, 1, 0, 0, 4'h0, 4'h4, 0, 7, 6, 1,  0, 0);
    vecs[14] = mk(0, 1, 0, 0, 4'h0, 4'h8, 0, 7, 7, 1,  0, 0);
    vecs[15] = mk(0, 1, 0, 0, 4'h0, 4'h1, 1, 8, 7, 1, 15, 1);
    vecs[16] = mk(0, 0, 0, 0, 4'h0, 4'h1, 0, 8, 7, 1, 15, 1);
    vecs[17] = mk(0, 0, 0, 1, 4'h0, 4'h1, 0, 0, 0, 0, 15, 1);
    vecs[18] = mk(0, 0, 1, 0, 4'hA, 4'hA, 0, 0, 0, 0,  0, 0);
    vecs[19] = mk(0, 0, 1, 0, 4'h0, 4'h1, 0, 0, 0, 0,  0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].clr, vecs[i].seed);
      cycle();
      chk("state",    i, state_a, vecs[i].exp_state);
      chk("lfsr_out", i, out_a,   vecs[i].exp_state[3]);
      chk("max_tick", i, tick_a,  vecs[i].exp_tick);
      chk("ones",     i, one_a,   vecs[i].exp_one);
      chk("zeros",    i, zero_a,  vecs[i].exp_zero);
      chk("pcnt",     i, pcnt_a,  vecs[i].exp_pcnt);
      chk("plen",     i, plen_a,  vecs[i].exp_plen);
      chk("pvalid",   i, valid_a, vecs[i].exp_valid);
    end

    // Two full periods with pattern 6; dut_b's 3-bit counters saturate.
    do_reset();
    steps(30);
    chk("p30_ticks", 0, ticks, 2);
    chk("p30_pcnt",  0, pcnt_a, 2);
    chk("p30_plen",  0, plen_a, 15);
    chk("p30_state", 0, state_a, 4'h1);
    chk("p30_ones",  0, one_a, 16);
    chk("p30_zeros", 0, zero_a, 14);
    chk("sat_ones",  0, one_b, 7);
    chk("sat_zeros", 0, zero_b, 7);
    chk("sat_pcnt",  0, pcnt_b, 2);
    chk("sat_plen",  0, plen_b, 7);
    chk("sat_valid", 0, valid_b, 1);

    // Mid-run reset restores every output of dut_b on the next cycle.
    do_reset();
    steps(20);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("rst_state", 0, state_b, 4'h1);
    chk("rst_tick",  0, tick_b, 0);
    chk("rst_ones",  0, one_b, 0);
    chk("rst_zeros", 0, zero_b, 0);
    chk("rst_pcnt",  0, pcnt_b, 0);
    chk("rst_plen",  0, plen_b, 0);
    chk("rst_valid", 0, valid_b, 0);

    // Load A, then one full period back to A.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'hA);
    cycle();
    chk("ldA_state", 0, state_a, 4'hA);
    chk("ldA_ones",  0, one_a, 0);
    chk("ldA_zeros", 0, zero_a, 0);
    ticks = 0;
    steps(14);
    chk("ldA_early_ticks", 0, ticks, 0);
    steps(1);
    chk("ldA_tick",  0, tick_a, 1);
    chk("ldA_state15", 0, state_a, 4'hA);
    chk("ldA_plen",  0, plen_a, 15);

    // A load mid-period discards the partial period.
    steps(14);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h1);
    cycle();
    steps(1);
    chk("ldmid_state", 0, state_a, 4'h3);
    chk("ldmid_tick",  0, tick_a, 0);
    chk("ldmid_valid", 0, valid_a, 0);

    // enable toggled every cycle: 15 real steps in 30 cycles.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, (i % 2 == 0), 1'b0, 1'b0, 4'h0);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("tog_ticks", 0, ticks, 1);
    chk("tog_state", 0, state_a, 4'h1);
    chk("tog_ones",  0, one_a, 8);
    chk("tog_zeros", 0, zero_a, 7);
    chk("tog_plen",  0, plen_a, 15);

    // stats_clear coincident with step 5 wins over that step's count.
    do_reset();
    steps(4);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("clr_state", 0, state_a, 4'hD);
    chk("clr_ones",  0, one_a, 0);
    chk("clr_zeros", 0, zero_a, 0);
    steps(10);
    chk("clr_tick",  0, tick_a, 1);
    chk("clr_sum",   0, one_a + zero_a, 10);
    chk("clr_ones10",  0, one_a, 6);
    chk("clr_zeros10", 0, zero_a, 4);
    chk("clr_plen",  0, plen_a, 15);
    cycle();
    chk("clr_tick_low", 0, tick_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
